// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank: FSM and decode encodings,
// the COMMIT/STATUS word offset, an index-width helper and the commit counter width.
package opb_regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KIND_DATA   = 2'd0,
        KIND_COMMIT = 2'd1,
        KIND_UNUSED = 2'd2
    } kind_t;

    localparam int CNT_W = 16;

    // COMMIT/STATUS sits directly after the last data word.
    function automatic int commit_offset(input int num_regs);
        return num_regs;
    endfunction

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/opb_reg_shadow_cell.sv
// One 32-bit control word: byte-enable shadow copy, active copy driven to user
// logic, pending flag, and a one-cycle update strobe when the active copy changes.
module opb_reg_shadow_cell #(
    parameter bit SHADOWED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    input  logic        commit,
    output logic [31:0] shadow,
    output logic [31:0] active,
    output logic        pending,
    output logic        update
);

    logic [31:0] shadow_reg;
    logic [31:0] active_reg;
    logic        pending_reg;
    logic        update_reg;
    logic [31:0] merged;

    // be[3] covers the most significant byte.
    always_comb begin
        merged = shadow_reg;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg  <= '0;
            active_reg  <= '0;
            pending_reg <= 1'b0;
            update_reg  <= 1'b0;
        end else begin
            update_reg <= 1'b0;
            if (wr_en && (|be)) begin
                shadow_reg <= merged;
                if (SHADOWED) begin
                    pending_reg <= 1'b1;
                end else begin
                    active_reg <= merged;
                    update_reg <= 1'b1;
                end
            end
            if (SHADOWED && commit && pending_reg) begin
                active_reg  <= shadow_reg;
                update_reg  <= 1'b1;
                pending_reg <= 1'b0;
            end
        end
    end

    assign shadow  = shadow_reg;
    assign active  = active_reg;
    assign pending = pending_reg;
    assign update  = update_reg;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS control words to user logic, with optional
// commit-based double buffering so multi-word settings update atomically.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01000500,
    parameter logic [31:0] C_HIGHADDR   = 32'h010005FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter int          C_SHADOWED   = 1,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:31]             OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:31]             OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:31]             Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0] user_data_out,
    output logic [C_NUM_REGS-1:0]   user_update
);

    localparam int COMMIT_OFF = commit_offset(C_NUM_REGS);
    localparam int IDX_W      = clog2(C_NUM_REGS + 1);
    localparam bit HAS_FAMILY = (C_FAMILY != "");
    localparam bit WIDTHS_OK  = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32);

    // Bus vectors are big-endian; these views put the bus LSB at bit 0.
    logic [31:0] addr;
    logic [31:0] wdata_bus;
    logic [3:0]  be_bus;
    logic [31:0] offset;
    logic [29:0] word;
    logic        hit;
    kind_t       kind;

    assign addr      = OPB_ABus;
    assign wdata_bus = OPB_DBus;
    assign be_bus    = OPB_BE;
    assign offset    = addr - C_BASEADDR;
    assign word      = offset[31:2];
    assign hit       = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

    always_comb begin
        kind = KIND_UNUSED;
        if (word < 30'(C_NUM_REGS)) begin
            kind = KIND_DATA;
        end else if (word == 30'(COMMIT_OFF)) begin
            kind = KIND_COMMIT;
        end
    end

    state_t             state_reg, state_next;
    kind_t              kind_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               rnw_reg;
    logic [3:0]         be_reg;
    logic [31:0]        wdata_reg;
    logic [31:0]        rdata_reg;
    logic [31:0]        rdata_next;
    logic [CNT_W-1:0]   count_reg;

    logic [31:0]            shadow_word [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]  pending_vec;
    logic                   any_pending;
    logic                   write_go;
    logic                   commit_go;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (hit) state_next = ST_DECODE;
            ST_DECODE: state_next = ST_ACK;
            ST_ACK:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // The beat is latched on entry to DECODE, so a master that drops select
    // early still gets a consistent single-beat transfer.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            kind_reg  <= KIND_UNUSED;
            idx_reg   <= '0;
            rnw_reg   <= 1'b0;
            be_reg    <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            count_reg <= '0;
        end else begin
            if ((state_reg == ST_IDLE) && hit) begin
                kind_reg  <= kind;
                idx_reg   <= word[IDX_W-1:0];
                rnw_reg   <= OPB_RNW;
                be_reg    <= be_bus;
                wdata_reg <= wdata_bus;
            end
            if (state_reg == ST_DECODE) begin
                rdata_reg <= rdata_next;
            end
            if (commit_go) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign any_pending = |pending_vec;

    always_comb begin
        rdata_next = '0;
        if (rnw_reg) begin
            case (kind_reg)
                KIND_DATA: begin
                    for (int i = 0; i < C_NUM_REGS; i++) begin
                        if (idx_reg == IDX_W'(i)) begin
                            rdata_next = shadow_word[i];
                        end
                    end
                end
                KIND_COMMIT: rdata_next = {count_reg, 15'd0, any_pending};
                default:     rdata_next = '0;
            endcase
        end
    end

    assign write_go  = (state_reg == ST_ACK) && !rnw_reg;
    assign commit_go = write_go && (kind_reg == KIND_COMMIT) && wdata_reg[0] && (C_SHADOWED != 0);

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_cell
            opb_reg_shadow_cell #(
                .SHADOWED (C_SHADOWED != 0)
            ) u_cell (
                .clk     (OPB_Clk),
                .rst_n   (OPB_Rst_n),
                .wr_en   (write_go && (kind_reg == KIND_DATA) && (idx_reg == IDX_W'(gi))),
                .be      (be_reg),
                .wdata   (wdata_reg),
                .commit  (commit_go),
                .shadow  (shadow_word[gi]),
                .active  (user_data_out[32*gi +: 32]),
                .pending (pending_vec[gi]),
                .update  (user_update[gi])
            );
        end
    endgenerate

    assign Sl_xferAck = (state_reg == ST_ACK);
    assign Sl_DBus    = Sl_xferAck ? rdata_reg : 32'd0;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, offset[1:0], HAS_FAMILY, WIDTHS_OK};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Randomized and directed bench for the OPB register bank: one shadowed and one
// direct-mode instance, checked against an array-based model of the register map.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h01000500;
    localparam logic [31:0] HIGH = 32'h010005FF;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [0:31] abus;
    logic [0:3]  be_bus;
    logic [0:31] dbus;
    logic        rnw, seq_addr, sel0, sel1;

    logic [0:31]      sl_dbus0, sl_dbus1;
    logic             ack0, ack1, err0, err1, retry0, retry1, tout0, tout1;
    logic [32*N-1:0]  udo0, udo1;
    logic [N-1:0]     upd0, upd1;

    opb_register_bank_ppc2simulink #(.C_NUM_REGS(N), .C_SHADOWED(1)) u_shadow (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be_bus),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel0), .OPB_seqAddr(seq_addr),
        .Sl_DBus(sl_dbus0), .Sl_xferAck(ack0), .Sl_errAck(err0), .Sl_retry(retry0),
        .Sl_toutSup(tout0), .user_data_out(udo0), .user_update(upd0)
    );

    opb_register_bank_ppc2simulink #(.C_NUM_REGS(N), .C_SHADOWED(0)) u_direct (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be_bus),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel1), .OPB_seqAddr(seq_addr),
        .Sl_DBus(sl_dbus1), .Sl_xferAck(ack1), .Sl_errAck(err1), .Sl_retry(retry1),
        .Sl_toutSup(tout1), .user_data_out(udo1), .user_update(upd1)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] sh_m  [N];
    logic [31:0] act_m [N];
    logic [31:0] dir_m [N];
    logic [N-1:0] pend_m;
    logic [15:0]  cnt_m;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_udo(input bit dev);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[32*i +: 32] = dev ? dir_m[i] : act_m[i];
        return r;
    endfunction

    // be[3] is OPB_BE[0], which selects the most significant byte.
    task automatic model_step(input bit dev, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] data, input bit rd_nwr,
                              output bit hit, output logic [31:0] rd, output logic [3:0] upd);
        logic [31:0] mask;
        int word;
        hit = (addr >= BASE) && (addr <= HIGH);
        rd = '0;
        upd = '0;
        if (!hit) return;
        word = int'((addr - BASE) >> 2);
        mask = '0;
        for (int j = 0; j < 4; j++) if (be[3-j]) mask |= 32'hFF << (24 - 8*j);
        if (word < N) begin
            if (rd_nwr) begin
                rd = dev ? dir_m[word] : sh_m[word];
            end else if (mask != 0) begin
                if (dev) begin
                    dir_m[word] = (dir_m[word] & ~mask) | (data & mask);
                    upd[word] = 1'b1;
                end else begin
                    sh_m[word] = (sh_m[word] & ~mask) | (data & mask);
                    pend_m[word] = 1'b1;
                end
            end
        end else if (word == N && !dev) begin
            if (rd_nwr) begin
                rd = {cnt_m, 15'd0, |pend_m};
            end else if (data[0]) begin
                for (int i = 0; i < N; i++) if (pend_m[i]) act_m[i] = sh_m[i];
                upd = pend_m;
                pend_m = '0;
                cnt_m = cnt_m + 16'd1;
            end
        end
    endtask

    task automatic xfer(input string tag, input bit dev, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data, input bit rd_nwr,
                        output logic [31:0] rd_obs);
        bit hit;
        logic [31:0] exp_rd, idle_bus;
        logic [3:0] exp_upd, ackv, upd2, upd3;
        logic [127:0] udo_before, udo2, udo3;
        udo_before = model_udo(dev);
        model_step(dev, addr, be, data, rd_nwr, hit, exp_rd, exp_upd);
        @(posedge clk); #1;
        abus = addr; be_bus = be; dbus = data; rnw = rd_nwr;
        if (dev) sel1 = 1'b1; else sel0 = 1'b1;
        @(negedge clk);
        ackv[3] = dev ? ack1 : ack0;
        @(negedge clk);
        ackv[2] = dev ? ack1 : ack0;
        idle_bus = dev ? sl_dbus1 : sl_dbus0;
        @(negedge clk);
        ackv[1] = dev ? ack1 : ack0;
        rd_obs = dev ? sl_dbus1 : sl_dbus0;
        upd2 = dev ? upd1 : upd0;
        udo2 = dev ? udo1 : udo0;
        @(posedge clk); #1;
        sel0 = 1'b0; sel1 = 1'b0;
        @(negedge clk);
        ackv[0] = dev ? ack1 : ack0;
        idle_bus = idle_bus | (dev ? sl_dbus1 : sl_dbus0);
        upd3 = dev ? upd1 : upd0;
        udo3 = dev ? udo1 : udo0;
        check({tag, " ack"}, ackv, hit ? 4'b0010 : 4'b0000);
        check({tag, " rdata"}, rd_obs, exp_rd);
        check({tag, " bus-idle"}, idle_bus, 32'd0);
        check({tag, " update"}, {upd2, upd3}, {4'b0000, exp_upd});
        check({tag, " out-at-ack"}, udo2, udo_before);
        check({tag, " out"}, udo3, model_udo(dev));
        $display("xfer %s dev=%0d addr=%h be=%b data=%h rnw=%0d rd=%h", tag, dev, addr, be, data, rd_nwr, rd_obs);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        int ack_count;
        abus = '0; be_bus = '0; dbus = '0; rnw = 1'b0; seq_addr = 1'b0;
        sel0 = 1'b0; sel1 = 1'b0;
        for (int i = 0; i < N; i++) begin sh_m[i] = '0; act_m[i] = '0; dir_m[i] = '0; end
        pend_m = '0;
        cnt_m = '0;

        repeat (3) @(negedge clk);
        check("reset handshake", {ack0, ack1, err0, err1, retry0, retry1, tout0, tout1}, 8'd0);
        check("reset dbus", {sl_dbus0, sl_dbus1}, 64'd0);
        check("reset out shadow", udo0, 128'd0);
        check("reset out direct", udo1, 128'd0);
        check("reset update", {upd0, upd1}, 8'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset lands while the write sits in DECODE.
        @(posedge clk); #1;
        abus = BASE; be_bus = 4'hF; dbus = 32'hCAFEF00D; rnw = 1'b0; sel0 = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; sel0 = 1'b0;
        @(negedge clk);
        check("midreset ack", {ack0, sl_dbus0}, 33'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        ack_count = 0;
        repeat (4) begin @(negedge clk); ack_count += int'(ack0); end
        check("midreset no ack", ack_count, 0);
        check("midreset out", udo0, 128'd0);
        xfer("midreset read0", 1'b0, BASE, 4'hF, 32'd0, 1'b1, rd);

        xfer("write reg1", 1'b0, BASE + 32'd4, 4'hF, 32'hDEADBEEF, 1'b0, rd);
        xfer("status pending", 1'b0, BASE + 32'd16, 4'hF, 32'd0, 1'b1, rd);
        check("status pending literal", rd, 32'h00000001);
        xfer("commit1", 1'b0, BASE + 32'd16, 4'hF, 32'd1, 1'b0, rd);
        check("commit word1 literal", udo0[63:32], 32'hDEADBEEF);
        xfer("status after commit", 1'b0, BASE + 32'd16, 4'hF, 32'd0, 1'b1, rd);
        check("status commit literal", rd, 32'h00010000);

        xfer("write reg0 full", 1'b0, BASE, 4'hF, 32'h11223344, 1'b0, rd);
        xfer("write reg0 be0101", 1'b0, BASE, 4'b0101, 32'hAABBCCDD, 1'b0, rd);
        xfer("read reg0", 1'b0, BASE, 4'hF, 32'd0, 1'b1, rd);
        check("byte enable literal", rd, 32'h11BB33DD);
        xfer("write reg2 be0", 1'b0, BASE + 32'd8, 4'h0, 32'hFFFFFFFF, 1'b0, rd);
        xfer("commit zero bit", 1'b0, BASE + 32'd16, 4'hF, 32'hFFFFFFFE, 1'b0, rd);
        xfer("commit2", 1'b0, BASE + 32'd16, 4'hF, 32'd1, 1'b0, rd);

        xfer("direct reg3", 1'b1, BASE + 32'd12, 4'hF, 32'h5, 1'b0, rd);
        check("direct word3 literal", udo1[127:96], 32'h5);
        xfer("direct commit noop", 1'b1, BASE + 32'd16, 4'hF, 32'd1, 1'b0, rd);

        xfer("read highaddr-3", 1'b0, HIGH - 32'd3, 4'hF, 32'd0, 1'b1, rd);
        check("highaddr literal", rd, 32'd0);
        xfer("select highaddr+1", 1'b0, HIGH + 32'd1, 4'hF, 32'd0, 1'b1, rd);
        xfer("select base-4", 1'b0, BASE - 32'd4, 4'hF, 32'h12345678, 1'b0, rd);
        xfer("unused write", 1'b0, BASE + 32'd20, 4'hF, 32'h87654321, 1'b0, rd);

        for (int k = 0; k < 60; k++) begin
            int r;
            bit dev, rd_nwr;
            logic [3:0] be;
            logic [31:0] data;
            r = int'($urandom_range(0, 9));
            dev = 1'($urandom_range(0, 1));
            rd_nwr = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            data = $urandom;
            if (r < 6) addr = BASE + 32'(4 * $urandom_range(0, N));
            else if (r < 8) addr = BASE + 32'(4 * $urandom_range(0, 63));
            else if (r == 8) addr = HIGH + 32'(1 + 4 * $urandom_range(0, 7));
            else addr = BASE - 32'(4 * $urandom_range(1, 8));
            xfer($sformatf("rand%0d", k), dev, addr, be, data, rd_nwr, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
# opb_register_bank_ppc2simulink

Parametrised successor to the single-word PPC-to-Simulink software register: an OPB slave presenting `C_NUM_REGS` 32-bit control words to user logic, with byte-enable writes, readback, and optional double-buffering. Writes land in shadow copies and are applied to all outputs atomically on a commit write, so multi-word settings (e.g. FIR coefficient pairs in the channeliser) never reach the datapath half-updated. It sits on the PPC OPB bus; user logic runs on the same clock.

## Interface
- `C_BASEADDR`, 32'h01000500: first byte address of window.
- `C_HIGHADDR`, 32'h010005FF: last byte address of window.
- `C_OPB_AWIDTH`, 32: address width.
- `C_OPB_DWIDTH`, 32: data width; only 32 supported.
- `C_NUM_REGS`, 4: register count, 1..63.
- `C_SHADOWED`, 1: 1 = commit-based shadow mode; 0 = direct write-through.
- `C_FAMILY`, "virtex5": target family string, passed through.

Ports:
- `OPB_Clk` in 1: the single clock for bus and user sides.
- `OPB_Rst_n` in 1: asynchronous, active-low reset.
- `OPB_ABus` in [0:31]: address.
- `OPB_BE` in [0:3]: byte enables; `BE[0]` covers `DBus[0:7]` (MSB byte).
- `OPB_DBus` in [0:31]: write data.
- `OPB_RNW` in 1: 1 = read.
- `OPB_select` in 1: transfer request.
- `OPB_seqAddr` in 1: sequential burst hint; ignored.
- `Sl_DBus` out [0:31]: read data; zero except in ack cycle.
- `Sl_xferAck` out 1: one-cycle transfer acknowledge.
- `Sl_errAck`, `Sl_retry`, `Sl_toutSup` out 1 each: tied 0.
- `user_data_out` out [32*C_NUM_REGS-1:0]: active words; reg i at `[32*i+31:32*i]`, LSB = `DBus[31]`.
- `user_update` out [C_NUM_REGS-1:0]: one-cycle strobe per word whose active value was just written.

## Operation
- Address map (word offsets from `C_BASEADDR`): 0..N-1 = data regs; N = COMMIT/STATUS; N+1..window end = unused.
- Hit = `OPB_select` high and address within `[C_BASEADDR, C_HIGHADDR]`; miss produces no response.
- FSM: IDLE -> (hit) DECODE -> ACK -> IDLE. DECODE registers index, RNW, BE, data; ACK drives `Sl_xferAck`=1 and read data. IDLE re-samples, so back-to-back beats cost 3 cycles each.
- Data write, shadowed: enabled bytes of shadow[i] updated in ACK; pending[i] set.
- Data write, direct: enabled bytes of active[i] updated in ACK; `user_update[i]` pulses next cycle.
- Data read: returns shadow[i] (equals active[i] in direct mode).
- COMMIT write with `DBus[31]`=1, shadowed: in ACK, active[i] <= shadow[i] for all pending i; `user_update` = pending mask next cycle; pending cleared; 16-bit commit counter increments, wrapping 65535 -> 0. `DBus[31]`=0 or direct mode: acked, no effect.
- STATUS read: `[0:15]` commit counter, `[16:30]` zero, `[31]` = OR of pending.
- Unused-offset access: acked; reads 0; writes dropped.
- `BE`=0000 write: acked, no change, no pending set.

## Timing
- Reset (async assert, sync deassert on `OPB_Clk`): FSM IDLE; all shadow, active, pending, counter = 0; `Sl_*`, `user_data_out`, `user_update` = 0.
- Select at cycle 0 -> `Sl_xferAck` at cycle 2 for exactly one cycle; `Sl_DBus` valid only then.
- `user_data_out` changes at cycle 3 (registered from ACK); `user_update` high in cycle 3 only.
- `OPB_select` dropped before ACK: ACK still completes, single beat; master ignores.
- Reset mid-transaction: no ack issued; no partial register update.
- Write to reg i after commit but before `user_update` falls: lands in shadow only, sets pending again.

## Structure
- Package `opb_regbank_pkg`: FSM state encoding, `COMMIT_OFFSET` function of `C_NUM_REGS`, `clog2` for index width, counter width 16.
- Sub-module `opb_reg_shadow_cell`: one word with byte-enable shadow, active copy, pending bit, commit input; generated `C_NUM_REGS` times. Bus decode, FSM, counter in top.

## Test plan
- Reset: assert `OPB_Rst_n`=0 mid-write -> all outputs 0, no ack, `user_data_out`=0 after release.
- Shadowed, N=4: write reg1=32'hDEADBEEF -> ack at cycle 2, `user_data_out` unchanged, STATUS reads 32'h00000001; commit -> word1=DEADBEEF, `user_update`=4'b0010 one cycle, STATUS=32'h00010000.
- Byte enables: reg0=32'h11223344, write 32'hAABBCCDD with BE=0101 -> readback 32'h11BB33DD.
- Direct mode (`C_SHADOWED`=0): write reg3=32'h5 -> word3=5 at cycle 3, `user_update`=4'b1000.
- Address edges: read `C_HIGHADDR`-3 -> ack, 0; select at `C_HIGHADDR`+1 -> no ack, `Sl_DBus`=0.
- Counter wrap: 65536 commits -> STATUS `[0:15]`=0.
